// File: rtl/adder_share_arb.sv
// Round-robin arbiter that time-shares one 64-bit carry-select adder among NREQ
// requesters and returns each result through a single registered response slot.
module adder_64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum
);
    logic [3:0] carry;

    assign carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_grp
            if (gi < 3) begin : g_sel
                logic [16:0] s0;
                logic [16:0] s1;
                assign s0 = {1'b0, a[16*gi +: 16]} + {1'b0, b[16*gi +: 16]};
                assign s1 = {1'b0, a[16*gi +: 16]} + {1'b0, b[16*gi +: 16]} + 17'd1;
                assign sum[16*gi +: 16] = carry[gi] ? s1[15:0] : s0[15:0];
                assign carry[gi+1]      = carry[gi] ? s1[16]    : s0[16];
            end else begin : g_top
                // Top group has no carry out to forward.
                logic [15:0] s0;
                logic [15:0] s1;
                assign s0 = a[16*gi +: 16] + b[16*gi +: 16];
                assign s1 = a[16*gi +: 16] + b[16*gi +: 16] + 16'd1;
                assign sum[16*gi +: 16] = carry[gi] ? s1 : s0;
            end
        end
    endgenerate
endmodule

module adder_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [64*NREQ-1:0]   req_a,
    input  logic [64*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [63:0]          resp_sum,
    output logic                 resp_cout,
    output logic                 resp_ovf
);
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic           state_reg;
    logic [IDW-1:0] rr_ptr_reg;
    logic [IDW-1:0] resp_id_reg;
    logic [63:0]    resp_sum_reg;
    logic           resp_cout_reg;
    logic           resp_ovf_reg;

    logic           can_accept;
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] rr_ptr_next;
    logic           accept;
    logic [63:0]    sel_a;
    logic [63:0]    sel_b;
    logic [63:0]    add_sum;
    logic           c63;
    logic           cout_next;
    logic           ovf_next;

    assign can_accept = !reset && ((state_reg == ST_EMPTY) || resp_ready);

    // Search from rr_ptr upward, wrapping, for the first valid requester.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = can_accept && grant_found && (grant_id == IDW'(gi));
        end
    endgenerate

    assign accept = |req_ready;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_id == IDW'(k)) begin
                sel_a = req_a[64*k +: 64];
                sel_b = req_b[64*k +: 64];
            end
        end
    end

    adder_64 u_adder (
        .a   (sel_a),
        .b   (sel_b),
        .sum (add_sum)
    );

    // Carry into bit 63 recovered from the sum, then the MSB full-adder carry.
    assign c63       = add_sum[63] ^ sel_a[63] ^ sel_b[63];
    assign cout_next = (sel_a[63] & sel_b[63]) | (c63 & (sel_a[63] ^ sel_b[63]));
    assign ovf_next  = (sel_a[63] == sel_b[63]) && (add_sum[63] != sel_a[63]);

    assign rr_ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_EMPTY;
            rr_ptr_reg    <= '0;
            resp_id_reg   <= '0;
            resp_sum_reg  <= '0;
            resp_cout_reg <= 1'b0;
            resp_ovf_reg  <= 1'b0;
        end else if (accept) begin
            state_reg     <= ST_FULL;
            rr_ptr_reg    <= rr_ptr_next;
            resp_id_reg   <= grant_id;
            resp_sum_reg  <= add_sum;
            resp_cout_reg <= cout_next;
            resp_ovf_reg  <= ovf_next;
        end else if (resp_ready) begin
            state_reg <= ST_EMPTY;
        end
    end

    assign resp_valid = (state_reg == ST_FULL);
    assign resp_id    = resp_id_reg;
    assign resp_sum   = resp_sum_reg;
    assign resp_cout  = resp_cout_reg;
    assign resp_ovf   = resp_ovf_reg;
endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: table vectors with fixed results plus rotation,
// backpressure and reset sequences checked through a response scoreboard.
module tb_adder_share_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [64*NREQ-1:0]   req_a;
    logic [64*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [63:0]          resp_sum;
    logic                 resp_cout;
    logic                 resp_ovf;

    always #5 clk = ~clk;

    adder_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [63:0]    sum;
        logic           cout;
        logic           ovf;
    } resp_t;

    typedef struct {
        int          id;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    resp_t sb_q[$];
    resp_t last_exp;
    vec_t  vecs[6];
    int    pass_cnt  = 0;
    int    total_cnt = 0;
    int    model_rr  = 0;
    logic  model_full = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b);
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
    endtask

    function automatic logic [NREQ-1:0] exp_grant(input logic [NREQ-1:0] v, input logic rst,
                                                  input logic rr);
        logic [NREQ-1:0] g;
        g = '0;
        if (!rst && (!model_full || rr)) begin
            for (int k = NREQ - 1; k >= 0; k--)
                if (v[(model_rr + k) % NREQ]) g = '0 | (NREQ'(1) << ((model_rr + k) % NREQ));
        end
        return g;
    endfunction

    // One clock: drive, check grant, clock, update model, check response slot.
    task automatic step(input logic [NREQ-1:0] v, input logic rr, input logic rst);
        logic [NREQ-1:0] g;
        logic [64:0]     full_sum;
        logic [63:0]     a;
        logic [63:0]     b;
        resp_t           e;
        int              idx;
        req_valid  = v;
        resp_ready = rr;
        reset      = rst;
        #2;
        g = exp_grant(v, rst, rr);
        check("req_ready", {60'd0, req_ready}, {60'd0, g});
        idx = 0;
        for (int k = 0; k < NREQ; k++) if (g[k]) idx = k;
        a = req_a[64*idx +: 64];
        b = req_b[64*idx +: 64];
        @(posedge clk);
        if (rst) begin
            model_full = 1'b0;
            model_rr   = 0;
            sb_q.delete();
            last_exp = '{id: '0, sum: '0, cout: 1'b0, ovf: 1'b0};
        end else if (g != '0) begin
            full_sum = {1'b0, a} + {1'b0, b};
            e.id   = IDW'(idx);
            e.sum  = full_sum[63:0];
            e.cout = full_sum[64];
            e.ovf  = (a[63] == b[63]) && (full_sum[63] != a[63]);
            sb_q.push_back(e);
            model_rr   = (idx + 1) % NREQ;
            model_full = 1'b1;
        end else if (rr) begin
            model_full = 1'b0;
        end
        #1;
        check("resp_valid", {63'd0, resp_valid}, {63'd0, model_full});
        if (!rst && g != '0 && sb_q.size() > 0) begin
            last_exp = sb_q.pop_front();
            $display("txn id=%0d a=%h b=%h sum=%h cout=%0b ovf=%0b", idx, a, b,
                     resp_sum, resp_cout, resp_ovf);
        end
        check("resp_id",   {62'd0, resp_id},   {62'd0, last_exp.id});
        check("resp_sum",  resp_sum,           last_exp.sum);
        check("resp_cout", {63'd0, resp_cout}, {63'd0, last_exp.cout});
        check("resp_ovf",  {63'd0, resp_ovf},  {63'd0, last_exp.ovf});
    endtask

    initial begin
        vecs[0] = '{id: 0, a: 64'd5, b: 64'd7, sum: 64'd12, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{id: 2, a: 64'hFFFFFFFFFFFFFFFF, b: 64'd1, sum: 64'd0, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{id: 2, a: 64'h7FFFFFFFFFFFFFFF, b: 64'd1, sum: 64'h8000000000000000,
                    cout: 1'b0, ovf: 1'b1};
        vecs[3] = '{id: 1, a: 64'h0000FFFFFFFFFFFF, b: 64'd1, sum: 64'h0001000000000000,
                    cout: 1'b0, ovf: 1'b0};
        vecs[4] = '{id: 3, a: 64'h0000FFFF0000FFFF, b: 64'h0000000100000001,
                    sum: 64'h0001000000010000, cout: 1'b0, ovf: 1'b0};
        vecs[5] = '{id: 1, a: 64'h8000000000000000, b: 64'h8000000000000000, sum: 64'd0,
                    cout: 1'b1, ovf: 1'b1};

        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        reset      = 1'b1;
        last_exp   = '{id: '0, sum: '0, cout: 1'b0, ovf: 1'b0};
        for (int i = 0; i < NREQ; i++) set_op(i, 64'd100 + 64'(i), 64'd1);
        @(posedge clk);
        #1;
        step('0, 1'b1, 1'b1);
        step('1, 1'b1, 1'b1);

        // Table vectors, one requester at a time, back to back.
        for (int i = 0; i < 6; i++) begin
            set_op(vecs[i].id, vecs[i].a, vecs[i].b);
            step(NREQ'(1) << vecs[i].id, 1'b1, 1'b0);
            check("tbl_sum",  resp_sum,           vecs[i].sum);
            check("tbl_cout", {63'd0, resp_cout}, {63'd0, vecs[i].cout});
            check("tbl_ovf",  {63'd0, resp_ovf},  {63'd0, vecs[i].ovf});
            check("tbl_id",   {62'd0, resp_id},   64'(vecs[i].id));
        end
        step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);

        // All requesters valid after reset: rotation 0,1,2,3,0 with no gaps.
        for (int i = 0; i < NREQ; i++) set_op(i, 64'h1000 * 64'(i + 1), 64'(i));
        step('0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step('1, 1'b1, 1'b0);
            check("rot_id", {62'd0, resp_id}, 64'(i % NREQ));
        end

        // Backpressure with reqs 1 and 3 pending, then release.
        for (int i = 0; i < 3; i++) step(4'b1010, 1'b0, 1'b0);
        step(4'b1010, 1'b1, 1'b0);
        check("bp_first", {62'd0, resp_id}, 64'd1);
        step(4'b1010, 1'b1, 1'b0);
        check("bp_second", {62'd0, resp_id}, 64'd3);
        step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);

        // Reset with a pending response and rr_ptr=2, request offered during reset.
        step('0, 1'b1, 1'b1);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0101, 1'b0, 1'b1);
        check("rst_clear", {63'd0, resp_valid}, 64'd0);
        step(4'b0101, 1'b1, 1'b0);
        check("rst_grant0", {62'd0, resp_id}, 64'd0);
        step('0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one combinational 64-bit carry-select adder (adder_64) among NREQ requesters.
- Typical requesters: fetch PC increment, execute ALU add, stack-pointer update, memory address calculation.
- Performs round-robin arbitration and valid/ready handshakes, and holds results in one registered response slot tagged with the requester ID.
- Instantiates exactly one adder_64. Operands are muxed into it, and its sum is captured in the response slot.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  64*NREQ  operand A; requester i occupies bits [64*i+63:64*i].
- req_b  input  64*NREQ  operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot grant; the request of requester i is accepted when req_valid[i] and req_ready[i] are both high.
- resp_valid  output  1  response slot holds a result.
- resp_ready  input  1  consumer accepts the response.
- resp_id  output  IDW  index of the requester that produced the result.
- resp_sum  output  64  A+B modulo 2**64.
- resp_cout  output  1  unsigned carry out of bit 63.
- resp_ovf  output  1  signed overflow: (A[63]==B[63]) and (sum[63]!=A[63]).

Behaviour:
- Reset (synchronous, active-high):
  - resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, resp_ovf=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is all zeros while reset is high.
- Slot state machine, 2 states:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
- can_accept = EMPTY, or (FULL and resp_ready). This gives full throughput: one result per cycle with no bubble.
- Grant (combinational):
  - When can_accept and any req_valid, grant the first valid requester found searching from rr_ptr upward, wrapping modulo NREQ.
  - req_ready is one-hot on that requester and zero elsewhere.
  - When not can_accept, req_ready is all zeros.
- req_ready depends on req_valid and resp_ready. Requesters must not make req_valid depend on req_ready.
- On an accepted request from requester g:
  - Route req_a[g] and req_b[g] into the adder.
  - Next cycle: resp_sum, resp_cout, resp_ovf and resp_id=g are registered, and resp_valid=1.
  - Latency is 1 cycle from the accept edge to resp_valid.
  - rr_ptr <= (g+1) mod NREQ.
- Carry out: the adder port provides only a 64-bit sum, so resp_cout is computed inside this block. Use the carry into bit 63 rebuilt from the sum and operand MSBs: c63 = sum[63]^A[63]^B[63], then cout = (A[63]&B[63]) | (c63&(A[63]^B[63])). A private 65-bit add is forbidden.
- FULL, resp_ready=1, no accept: go to EMPTY and clear resp_valid. The data fields hold their last values.
- FULL, resp_ready=0: all response outputs hold stable, and no requester is granted.
- EMPTY, no req_valid: stay EMPTY; rr_ptr holds.
- Simultaneous consume and accept in one cycle: the slot is overwritten with the new result, and resp_valid stays 1.
- Reset asserted mid-operation: a pending response is discarded and rr_ptr returns to 0. A request presented in the reset cycle is not accepted.
- Arithmetic wraps modulo 2**64; there is no saturation.
- Unused ID encodings (NREQ < 2**IDW) never appear on resp_id.

Test Plan:
- Reset, then only req 0 valid with A=5, B=7, resp_ready=1 -> req_ready=0001. Next cycle: resp_valid=1, resp_id=0, resp_sum=12, cout=0, ovf=0.
- All 4 requesters valid continuously, resp_ready=1 -> grants rotate 0,1,2,3,0 on consecutive cycles, and resp_id follows one cycle later with no gap cycles.
- req 2 with A=0xFFFFFFFFFFFFFFFF, B=1 -> sum=0, cout=1, ovf=0. Then A=0x7FFFFFFFFFFFFFFF, B=1 -> sum=0x8000000000000000, cout=0, ovf=1.
- Response pending with resp_ready=0 for 3 cycles while reqs 1 and 3 are valid -> req_ready=0 throughout and outputs stable. When resp_ready rises: grant req 1 that cycle, then req 3 next.
- Carry crossing the 16-bit group boundaries: A=0x0000FFFFFFFFFFFF, B=1 -> sum=0x0001000000000000. A=0x0000FFFF0000FFFF, B=0x0000000100000001 -> sum=0x0001000000010000.
- Reset asserted while resp_valid=1 and rr_ptr=2 -> next cycle resp_valid=0. After reset, reqs 0 and 2 both valid -> req 0 granted first.
